// File: rtl/icache_refill_master_pkg.sv
// Shared AHB-lite and refill definitions for the I-cache refill path.
package icache_refill_master_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam logic [2:0]  HSIZE_WORD = 3'b010;

  // AHB-lite transfer types
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_types_e;

  // AHB-lite burst types
  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } burst_types_e;

  // Refill sequencer states
  typedef enum logic [2:0] {
    RS_IDLE  = 3'd0,
    RS_ADDR  = 3'd1,
    RS_BURST = 3'd2,
    RS_DRAIN = 3'd3,
    RS_DONE  = 3'd4
  } refill_state_t;

  // Word slot within a line for beat k of a burst starting at word crit.
  function automatic logic [1:0] wrap_idx(input logic [1:0] crit, input logic [1:0] beat);
    return crit + beat;
  endfunction

endpackage

// File: rtl/icache_wrap_addr_gen.sv
// Combinational WRAP4 word-address generator: line base + critical index + beat.
module icache_wrap_addr_gen
  import icache_refill_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-5:0] line_base,
  input  logic [1:0]        crit_idx,
  input  logic [1:0]        beat,
  output logic [ADDR_W-1:0] word_addr_c
);

  // Wrapped word address; the line base never increments.
  always_comb begin
    word_addr_c = {line_base, wrap_idx(crit_idx, beat), 2'b00};
  end

endmodule

// File: rtl/icache_refill_master.sv
// AHB-lite refill master: one WRAP4 read burst per line miss, critical word first.
// Optional build macro REFILL_ERR_EN adds hresp and ERROR-terminated fills.
module icache_refill_master
  import icache_refill_master_pkg::*;
#(
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 hclk,
  input  logic                 hrstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 crit_valid,
  output logic [WORD_W-1:0]    crit_data,
  output logic                 fill_valid,
  output logic [ADDR_W-1:0]    fill_addr,
  output logic [LINE_BITS-1:0] fill_line,
  output logic                 fill_err,
  output logic [ADDR_W-1:0]    haddr,
  output logic [1:0]           htrans,
  output logic [2:0]           hburst,
  output logic [2:0]           hsize,
  output logic                 hwrite,
  input  logic                 hready,
  input  logic [WORD_W-1:0]    hrdata
`ifdef REFILL_ERR_EN
  ,
  input  logic                 hresp
`endif
);

  refill_state_t  state_q, state_n;
  logic [1:0]     acnt_q, acnt_n;
  logic [1:0]     dcnt_q, dcnt_n;
  logic           err_q, err_n;
  logic [ADDR_W-5:0] base_q, base_n;
  logic [1:0]     crit_idx_q, crit_idx_n;
  trans_types_e   htrans_q, htrans_n;
  logic           req_ready_n;
  logic           crit_valid_n;
  logic [WORD_W-1:0] crit_data_n;
  logic           fill_valid_n;
  logic           fill_err_n;
  logic [ADDR_W-1:0] fill_addr_n;
  logic [LINE_BITS-1:0] fill_line_n;
  logic           capture;
  logic           finish;
  logic [1:0]     slot;
  logic [ADDR_W-1:0] haddr_c;
  logic           resp_err;

`ifdef REFILL_ERR_EN
  assign resp_err = hresp;
`else
  assign resp_err = 1'b0;
`endif

  assign hburst = BURST_WRAP4;
  assign hsize  = HSIZE_WORD;
  assign hwrite = 1'b0;
  assign htrans = htrans_q;
  assign slot   = wrap_idx(crit_idx_q, dcnt_q);

  // Address for the next address phase, from next-state counters.
  icache_wrap_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .line_base   (base_n),
    .crit_idx    (crit_idx_n),
    .beat        (acnt_n),
    .word_addr_c (haddr_c)
  );

  // Next-state, bus control and data capture.
  always_comb begin
    state_n      = state_q;
    acnt_n       = acnt_q;
    dcnt_n       = dcnt_q;
    err_n        = err_q;
    base_n       = base_q;
    crit_idx_n   = crit_idx_q;
    htrans_n     = TRANS_IDLE;
    req_ready_n  = 1'b0;
    crit_valid_n = 1'b0;
    crit_data_n  = crit_data;
    fill_valid_n = 1'b0;
    fill_err_n   = fill_err;
    fill_addr_n  = fill_addr;
    fill_line_n  = fill_line;
    capture      = 1'b0;
    finish       = 1'b0;

    case (state_q)
      RS_IDLE: begin
        req_ready_n = 1'b1;
        if (req_valid) begin
          base_n      = req_addr[ADDR_W-1:4];
          crit_idx_n  = req_addr[3:2];
          acnt_n      = 2'd0;
          dcnt_n      = 2'd0;
          err_n       = 1'b0;
          fill_err_n  = 1'b0;
          htrans_n    = TRANS_NONSEQ;
          req_ready_n = 1'b0;
          state_n     = RS_ADDR;
        end
      end
      RS_ADDR: begin
        htrans_n = TRANS_NONSEQ;
        if (hready) begin
          acnt_n   = 2'd1;
          htrans_n = TRANS_SEQ;
          state_n  = RS_BURST;
        end
      end
      RS_BURST: begin
        htrans_n = TRANS_SEQ;
        if (resp_err && !hready) begin
          // First ERROR cycle: cancel the remaining beats from the next cycle.
          err_n    = 1'b1;
          htrans_n = TRANS_IDLE;
          state_n  = RS_DRAIN;
        end else if (hready) begin
          if (resp_err) begin
            finish = 1'b1;
          end else begin
            capture = 1'b1;
            if (acnt_q == 2'd3) begin
              htrans_n = TRANS_IDLE;
              state_n  = RS_DRAIN;
            end else begin
              acnt_n = acnt_q + 2'd1;
            end
          end
        end
      end
      RS_DRAIN: begin
        if (resp_err && !hready) begin
          err_n = 1'b1;
        end else if (hready) begin
          capture = !(resp_err || err_q);
          finish  = 1'b1;
        end
      end
      RS_DONE: begin
        req_ready_n = 1'b1;
        state_n     = RS_IDLE;
      end
      default: begin
        state_n = RS_IDLE;
      end
    endcase

    // Store the beat in its address-ordered slot; the first beat is the critical word.
    if (capture) begin
      fill_line_n[{slot, 5'b00000} +: WORD_W] = hrdata;
      dcnt_n = dcnt_q + 2'd1;
      if (dcnt_q == 2'd0) begin
        crit_data_n  = hrdata;
        crit_valid_n = 1'b1;
      end
    end

    // Last data phase (or second ERROR cycle) closes the line.
    if (finish) begin
      htrans_n     = TRANS_IDLE;
      fill_valid_n = 1'b1;
      fill_err_n   = err_q | resp_err;
      fill_addr_n  = {base_q, 4'b0000};
      state_n      = RS_DONE;
    end
  end

  // FSM state register.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q <= RS_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      acnt_q     <= 2'd0;
      dcnt_q     <= 2'd0;
      err_q      <= 1'b0;
      base_q     <= '0;
      crit_idx_q <= 2'd0;
      htrans_q   <= TRANS_IDLE;
      haddr      <= '0;
      req_ready  <= 1'b1;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      fill_valid <= 1'b0;
      fill_err   <= 1'b0;
      fill_addr  <= '0;
      fill_line  <= '0;
    end else begin
      acnt_q     <= acnt_n;
      dcnt_q     <= dcnt_n;
      err_q      <= err_n;
      base_q     <= base_n;
      crit_idx_q <= crit_idx_n;
      htrans_q   <= htrans_n;
      if (htrans_n != TRANS_IDLE) begin
        haddr <= haddr_c;
      end
      req_ready  <= req_ready_n;
      crit_valid <= crit_valid_n;
      crit_data  <= crit_data_n;
      fill_valid <= fill_valid_n;
      fill_err   <= fill_err_n;
      fill_addr  <= fill_addr_n;
      fill_line  <= fill_line_n;
    end
  end

endmodule

// File: tb/tb_icache_refill_master.sv
// Scoreboard bench for icache_refill_master with a small AHB-lite slave model.
`timescale 1ns/1ps
module tb_icache_refill_master;

  logic         hclk = 1'b0;
  logic         hrstn;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] fill_line;
  logic         fill_err;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic [2:0]   hsize;
  logic         hwrite;
  logic         hready;
  logic [31:0]  hrdata;
  logic         hresp;

  icache_refill_master dut (
    .hclk       (hclk),
    .hrstn      (hrstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .crit_valid (crit_valid),
    .crit_data  (crit_data),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_line  (fill_line),
    .fill_err   (fill_err),
    .haddr      (haddr),
    .htrans     (htrans),
    .hburst     (hburst),
    .hsize      (hsize),
    .hwrite     (hwrite),
    .hready     (hready),
    .hrdata     (hrdata)
`ifdef REFILL_ERR_EN
    ,
    .hresp      (hresp)
`endif
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int cyc; } crit_exp_t;
  typedef struct { logic [31:0] addr; logic [127:0] line; logic err; int cyc; } fill_exp_t;

  crit_exp_t   crit_q[$];
  fill_exp_t   fill_q[$];
  logic [31:0] addr_q[$];

  // Slave configuration: which data beat stalls / errors.
  int wait_beat = -1;
  int n_wait    = 0;
  int err_beat  = -1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // AHB-lite slave: memory word at A is A ^ 0xA5A5_0000.
  logic [1:0]  p_htrans;
  logic [31:0] p_haddr;
  logic        p_hready;
  logic        p_hresp;
  logic        dp_active;
  logic [31:0] dp_addr;
  int          dp_wait;
  int          dp_err;
  int          beat;

  always @(negedge hclk) begin
    if (!hrstn) begin
      dp_active = 1'b0;
      dp_wait   = 0;
      dp_err    = 0;
      beat      = 0;
      hready    = 1'b1;
      hresp     = 1'b0;
      hrdata    = '0;
      p_hready  = 1'b1;
      p_hresp   = 1'b0;
      p_htrans  = 2'b00;
      p_haddr   = '0;
    end else begin
      if (!p_hready && p_hresp)
        chk("htrans_idle_after_error", 128'(htrans), 128'(2'b00));
      if (!p_hready && !p_hresp && p_htrans != 2'b00) begin
        chk("htrans_held_in_wait", 128'(htrans), 128'(p_htrans));
        chk("haddr_held_in_wait", 128'(haddr), 128'(p_haddr));
      end
      if (p_hready) begin
        if (p_htrans[1]) begin
          checks++;
          if (addr_q.size() == 0) begin
            errors++;
            $display("FAIL bus_addr: unexpected address phase %h (cycle %0d)", p_haddr, cyc);
          end else begin
            logic [31:0] ea;
            ea = addr_q.pop_front();
            if (p_haddr !== ea) begin
              errors++;
              $display("FAIL bus_addr: got %h expected %h (cycle %0d)", p_haddr, ea, cyc);
            end
          end
          beat      = (p_htrans == 2'b10) ? 0 : beat + 1;
          dp_active = 1'b1;
          dp_addr   = p_haddr;
          dp_wait   = (beat == wait_beat) ? n_wait : 0;
          dp_err    = (beat == err_beat) ? 2 : 0;
        end else begin
          dp_active = 1'b0;
        end
      end
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;
      if (dp_active) begin
        if (dp_err == 2) begin
          hready = 1'b0; hresp = 1'b1; dp_err = 1;
        end else if (dp_err == 1) begin
          hready = 1'b1; hresp = 1'b1; dp_err = 0;
        end else if (dp_wait > 0) begin
          hready = 1'b0; dp_wait--;
        end else begin
          hrdata = dp_addr ^ 32'hA5A5_0000;
        end
      end
      p_hready = hready;
      p_hresp  = hresp;
      p_htrans = htrans;
      p_haddr  = haddr;
    end
  end

  // Output monitor: pops expected crit/fill events whenever the DUT pulses them.
  crit_exp_t ce;
  fill_exp_t fe;
  always @(negedge hclk) begin
    if (hrstn) begin
      if (crit_valid) begin
        if (crit_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL crit_unexpected: crit_data %h at cycle %0d", crit_data, cyc);
        end else begin
          ce = crit_q.pop_front();
          chk("crit_data", 128'(crit_data), 128'(ce.data));
          chk("crit_cycle", 128'(cyc), 128'(ce.cyc));
        end
      end
      if (fill_valid) begin
        if (fill_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fill_unexpected: fill_addr %h at cycle %0d", fill_addr, cyc);
        end else begin
          fe = fill_q.pop_front();
          chk("fill_addr", 128'(fill_addr), 128'(fe.addr));
          chk("fill_err", 128'(fill_err), 128'(fe.err));
          chk("fill_cycle", 128'(cyc), 128'(fe.cyc));
          if (!fe.err) chk("fill_line", fill_line, fe.line);
        end
      end
    end
  end

  // Issue one request (called at a negedge); pushes expectations on acceptance.
  task automatic do_req(input logic [31:0] a, input int wb, input int nw, input int eb,
                        input int n_addr, input bit exp_fill, output int t);
    logic [31:0] base;
    logic [1:0]  c;
    logic [1:0]  w;
    crit_exp_t   ec;
    fill_exp_t   ef;
    wait_beat = wb;
    n_wait    = nw;
    err_beat  = eb;
    base      = {a[31:4], 4'h0};
    c         = a[3:2];
    req_addr  = a;
    req_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 100 && t < 0; i++) begin
      if (req_ready) t = cyc;
      else @(negedge hclk);
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL req_accept: request %h not accepted within 100 cycles", a);
      req_valid = 1'b0;
      return;
    end
    for (int k = 0; k < n_addr; k++) begin
      w = c + 2'(k);
      addr_q.push_back({base[31:4], w, 2'b00});
    end
    if (eb != 0) begin
      ec.data = {base[31:4], c, 2'b00} ^ 32'hA5A5_0000;
      ec.cyc  = t + 3 + ((wb == 0) ? nw : 0);
      crit_q.push_back(ec);
    end
    if (exp_fill) begin
      ef.addr = base;
      ef.err  = (eb >= 0);
      ef.cyc  = (eb >= 0) ? t + 4 + eb : t + 6 + nw;
      for (int k = 0; k < 4; k++) begin
        w = 2'(k);
        ef.line[32*k +: 32] = {base[31:4], w, 2'b00} ^ 32'hA5A5_0000;
      end
      fill_q.push_back(ef);
    end
    @(negedge hclk);
    req_valid = 1'b0;
  endtask

  // Wait for all expected events to drain and the block to go idle.
  task automatic wait_idle(input string name);
    int n = 0;
    while ((crit_q.size() != 0 || fill_q.size() != 0 || addr_q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge hclk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain: pending crit %0d fill %0d addr %0d req_ready %0b", name,
               crit_q.size(), fill_q.size(), addr_q.size(), req_ready);
      crit_q.delete(); fill_q.delete(); addr_q.delete();
    end
    chk({name, "_htrans_idle"}, 128'(htrans), 128'(2'b00));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3;
    req_valid = 1'b0;
    req_addr  = '0;
    hrstn     = 1'b1;
    #3 hrstn = 1'b0;
    repeat (2) @(negedge hclk);

    // Reset state
    chk("rst_req_ready", 128'(req_ready), 128'(1'b1));
    chk("rst_crit_valid", 128'(crit_valid), 128'(1'b0));
    chk("rst_fill_valid", 128'(fill_valid), 128'(1'b0));
    chk("rst_fill_err", 128'(fill_err), 128'(1'b0));
    chk("rst_htrans", 128'(htrans), 128'(2'b00));
    chk("rst_haddr", 128'(haddr), 128'(32'h0));
    chk("rst_crit_data", 128'(crit_data), 128'(32'h0));
    chk("rst_fill_line", fill_line, 128'h0);
    chk("rst_fill_addr", 128'(fill_addr), 128'(32'h0));
    chk("hburst_wrap4", 128'(hburst), 128'(3'b010));
    chk("hsize_word", 128'(hsize), 128'(3'b010));
    chk("hwrite_zero", 128'(hwrite), 128'(1'b0));
    hrstn = 1'b1;
    repeat (2) @(negedge hclk);

    // Zero-wait, critical word 2
    do_req(32'h0000_1008, -1, 0, -1, 4, 1'b1, t1);
    wait_idle("zero_wait");

    // Critical word 3 wraps; two wait states on the third data phase
    do_req(32'h0000_200C, 2, 2, -1, 4, 1'b1, t1);
    wait_idle("wrap_wait");

    // Back-to-back requests with req_valid held high
    do_req(32'h0000_0100, -1, 0, -1, 4, 1'b1, t1);
    do_req(32'h0000_0300, -1, 0, -1, 4, 1'b1, t2);
    chk("b2b_accept_cycle", 128'(t2), 128'(t1 + 7));
    wait_idle("back_to_back");

    // Reset mid-burst: crit pulse already out, no fill
    do_req(32'h0000_0704, -1, 0, -1, 2, 1'b0, t3);
    @(negedge hclk);
    @(negedge hclk);
    #2 hrstn = 1'b0;
    #1;
    chk("midrst_req_ready", 128'(req_ready), 128'(1'b1));
    chk("midrst_htrans", 128'(htrans), 128'(2'b00));
    chk("midrst_haddr", 128'(haddr), 128'(32'h0));
    chk("midrst_crit_valid", 128'(crit_valid), 128'(1'b0));
    chk("midrst_fill_valid", 128'(fill_valid), 128'(1'b0));
    chk("midrst_fill_line", fill_line, 128'h0);
    repeat (3) @(negedge hclk);
    hrstn = 1'b1;
    repeat (2) @(negedge hclk);
    chk("midrst_cycle_count", 128'(cyc > t3 + 3), 128'(1'b1));
    do_req(32'h0000_0400, -1, 0, -1, 4, 1'b1, t1);
    wait_idle("after_reset");

`ifdef REFILL_ERR_EN
    // ERROR on the second data phase cancels the rest of the burst
    do_req(32'h0000_0500, -1, 0, 1, 2, 1'b1, t1);
    wait_idle("error_beat1");
`else
    // Without the error option the same request is a normal fill
    do_req(32'h0000_0500, -1, 0, -1, 4, 1'b1, t1);
    wait_idle("no_err_option");
`endif

    repeat (3) @(negedge hclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_master.md
Name: icache_refill_master

Overview:
- AHB-lite master stage directly downstream of the I-cache lookup.
- Takes one line-miss request and issues a single WRAP4 word burst, critical word first.
- Forwards the critical word early, then returns the assembled 128-bit line and its line address for cache write.
- Owns the downstream bus: the cache no longer drives haddr/htrans/hburst itself.

Parameters:
- LINE_BITS, 128, cache line width; only 128 is legal, since it matches WRAP4 × 32-bit.
- ADDR_W, 32, address width.

Ports:
- hclk  in  1  clock
- hrstn  in  1  async active-low reset
- req_valid  in  1  miss request
- req_ready  out  1  block idle, can accept a request
- req_addr  in  32  miss address; bits [3:2] select the critical word
- crit_valid  out  1  one-cycle pulse, critical word available
- crit_data  out  32  critical word
- fill_valid  out  1  one-cycle pulse, line complete
- fill_addr  out  32  line-aligned address ({req_addr[31:4],4'b0})
- fill_line  out  128  word i in bits [32i+31:32i], by address order, not arrival order
- fill_err  out  1  valid with fill_valid; burst ended in ERROR
- haddr  out  32  AHB address
- htrans  out  2  AHB transfer type
- hburst  out  3  constant WRAP4 (3'b010)
- hsize  out  3  constant WORD (3'b010)
- hwrite  out  1  constant 0
- hready  in  1  downstream ready
- hrdata  in  32  downstream read data
- hresp  in  1  only present with REFILL_ERR_EN

Behaviour:
- Single clock hclk; reset hrstn is asynchronous, active-low.
- Reset values:
  - req_ready=1; crit_valid=0; fill_valid=0; fill_err=0.
  - htrans=IDLE (2'b00); haddr=0; crit_data=0; fill_line=0; fill_addr=0.
  - FSM in IDLE; counters 0.
- Handshake: a request is accepted at edge T when req_valid && req_ready. req_ready is high only in IDLE. The address is latched at acceptance.
- FSM states: IDLE, ADDR, BURST, DRAIN, DONE.
  - IDLE → ADDR on accept.
  - ADDR: htrans=NONSEQ, haddr=critical word address. Holds while hready=0; → BURST on hready=1.
  - BURST: htrans=SEQ. haddr = {line[31:4], (crit+k) mod 4, 2'b00} for k=1..3. Address counter advances only on hready=1. After beat k=3 is accepted → DRAIN.
  - DRAIN: htrans=IDLE. Waits for the last data phase (hready=1) → DONE.
  - DONE: fill_valid=1 for one cycle → IDLE (req_ready=1 again the next cycle).
- Data capture:
  - hrdata is sampled on every hready=1 cycle that has an outstanding data phase.
  - A 2-bit data counter tracks the wrap index. Each word is written to its line slot by address bits [3:2].
- Critical word:
  - The first data beat is registered into crit_data.
  - crit_valid pulses the cycle after that beat is sampled.
- Zero-wait timing, from acceptance at T:
  - NONSEQ at T+1; SEQ at T+2..T+4.
  - Data phases T+2..T+5.
  - crit_valid at T+3; fill_valid at T+6.
- Wait states stretch the schedule; address and data-phase ownership follow AHB-lite pipelining exactly.
- Wrap-around: crit=3 gives address order 0xC, 0x0, 0x4, 0x8 within the line; the line base never increments.
- req_valid is ignored outside IDLE. A request presented in the same cycle as the DONE pulse is accepted on the following cycle.
- Reset mid-burst:
  - Immediate return to IDLE with htrans=IDLE.
  - No fill_valid or crit_valid; partial line discarded.

Optional Feature:
- REFILL_ERR_EN defined:
  - hresp port exists.
  - hresp=1 with hready=0 (first ERROR cycle): htrans is driven IDLE from the next cycle, cancelling remaining beats.
  - The second ERROR cycle (hready=1) goes → DONE with fill_valid=1, fill_err=1, and undefined line contents.
  - crit_valid is suppressed if the critical beat itself errored.
- Not defined: no hresp port; fill_err tied 0; all responses treated as OKAY.

Decomposition:
- Shared package (interface package): existing BURST_TYPES/TRANS_TYPES enums; new REFILL_STATE_T enum; constants LINE_WORDS=4, HSIZE_WORD=3'b010.
- One sub-module, icache_wrap_addr_gen: combinational; line base, crit index, beat k → wrapped word address. Reused by the cache for line-slot indexing.

Test Plan:
- Zero-wait, req_addr=0x0000_1008, memory word at A = A^0xA5A5_0000:
  - haddr sequence 0x1008, 0x100C, 0x1000, 0x1004.
  - crit_data=0xA5A5_1008, crit_valid at T+3.
  - fill_valid at T+6; fill_line[31:0]=0xA5A5_1000; fill_addr=0x1000.
- req_addr=0x0000_200C, 2 wait states on beat 2:
  - Wrap order C, 0, 4, 8; address held during waits.
  - fill_valid at T+8; line words in address order.
- Back-to-back: req_valid held high for two requests (0x100, 0x300):
  - Second request accepted the cycle after the first fill_valid.
  - No address overlap between bursts.
- hrstn asserted at T+3 of a burst:
  - Outputs immediately at reset values; no fill_valid.
  - After release, a new request 0x400 completes normally.
- With REFILL_ERR_EN, ERROR on beat 1 of req 0x500:
  - htrans=IDLE the cycle after hresp=1.
  - fill_valid=1 with fill_err=1; remaining beats not issued.
- Without REFILL_ERR_EN, same stimulus (no hresp): normal 4-beat fill, fill_err=0.
